// File: rtl/logic_gate_pipe.sv
// Handshaked WIDTH-bit logic unit (AND/OR/XOR/NAND) whose registered results are
// buffered in a DEPTH-entry first-word-fall-through FIFO, plus a consumed-result counter.
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic [1:0]                 op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           y,
    output logic                       zero,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [15:0]                ops_done
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [WIDTH-1:0] result;
    logic             push;
    logic             pop;

    // Status comes from registered occupancy only; full/empty never compare pointers.
    assign in_ready  = !rst && (count != FULL);
    assign out_valid = (count != '0);
    assign y         = out_valid ? mem[head] : '0;
    assign zero      = out_valid && (y == '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // NOTE: result gets a value before the case so no path leaves it unassigned (no latch).
    always_comb begin
        result = a & b;
        case (op_e'(op))
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NAND: result = ~(a & b);
            default: result = a & b;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            ops_done <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head     <= head + PW'(1);
                ops_done <= ops_done + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= result;
        end
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Scoreboard bench for logic_gate_pipe: expected results are queued at push time
// and compared when the consumer pops them.
module tb_logic_gate_pipe;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic [1:0]       op        = '0;
    logic             in_ready;
    logic             out_valid;
    logic             zero;
    logic [WIDTH-1:0] y;
    logic [CW-1:0]    count;
    logic [15:0]      ops_done;

    int               vectors     = 0;
    int               miscompares = 0;
    logic [WIDTH-1:0] sb[$];
    logic [15:0]      exp_ops     = '0;

    always #5 clk = ~clk;

    logic_gate_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero), .count(count), .ops_done(ops_done)
    );

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] fa, input logic [WIDTH-1:0] fb,
                                               input logic [1:0] fop);
        case (fop)
            2'b00:   return fa & fb;
            2'b01:   return fa | fb;
            2'b10:   return fa ^ fb;
            default: return ~(fa & fb);
        endcase
    endfunction

    // One clock: compare outputs against the model, update the scoreboard, step past the edge.
    task automatic tick(input bit full_chk);
        logic [WIDTH-1:0] head_exp;
        logic [CW-1:0]    cnt_exp;
        bit               rdy_exp;
        bit               vld_exp;
        bit               do_push;
        bit               do_pop;
        rdy_exp  = (sb.size() < DEPTH);
        vld_exp  = (sb.size() != 0);
        cnt_exp  = CW'(sb.size());
        head_exp = vld_exp ? sb[0] : '0;
        do_push  = in_valid && rdy_exp;
        do_pop   = out_ready && vld_exp;
        if (full_chk) begin
            vectors += 4;
            if (in_ready !== rdy_exp) begin
                miscompares++;
                $display("FAIL in_ready: got %b want %b at %0t", in_ready, rdy_exp, $time);
            end
            if (out_valid !== vld_exp) begin
                miscompares++;
                $display("FAIL out_valid: got %b want %b at %0t", out_valid, vld_exp, $time);
            end
            if (count !== cnt_exp) begin
                miscompares++;
                $display("FAIL count: got %0d want %0d at %0t", count, cnt_exp, $time);
            end
            if (zero !== (vld_exp && head_exp == '0)) begin
                miscompares++;
                $display("FAIL zero: got %b want %b at %0t", zero, vld_exp && head_exp == '0, $time);
            end
        end
        if (full_chk || do_pop) begin
            vectors++;
            if (y !== head_exp) begin
                miscompares++;
                $display("FAIL y: got %h want %h at %0t", y, head_exp, $time);
            end
        end
        if (do_pop) begin
            void'(sb.pop_front());
            exp_ops++;
        end
        if (do_push) sb.push_back(model(a, b, op));
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                         input logic [1:0] dop, input bit full_chk);
        bit acc;
        a        = da;
        b        = db;
        op       = dop;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = (sb.size() < DEPTH);
            tick(full_chk);
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL drive_timeout: push not accepted, got count %0d want below %0d", count, DEPTH);
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && sb.size() != 0; i++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            tick(1'b1);
        end
        vectors++;
        if (sb.size() != 0 || count !== '0) begin
            miscompares++;
            $display("FAIL drain: got count %0d want 0 (%0d results undelivered)", count, sb.size());
        end
    endtask

    task automatic test_reset();
        #2;
        vectors += 6;
        if (count !== '0)      begin miscompares++; $display("FAIL rst_count: got %0d want 0", count); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        if (y !== '0)          begin miscompares++; $display("FAIL rst_y: got %h want 00", y); end
        if (zero !== 1'b0)     begin miscompares++; $display("FAIL rst_zero: got %b want 0", zero); end
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        if (ops_done !== '0)   begin miscompares++; $display("FAIL rst_ops_done: got %0d want 0", ops_done); end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_basic_ops();
        logic [WIDTH-1:0] tbl [4];
        tbl       = '{8'h30, 8'hFC, 8'hCC, 8'hCF};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(8'hF0, 8'h3C, 2'(i), 1'b1);
            vectors += 2;
            if (out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL basic_valid[%0d]: got %b want 1", i, out_valid);
            end
            if (y !== tbl[i]) begin
                miscompares++;
                $display("FAIL basic_y[%0d]: got %h want %h", i, y, tbl[i]);
            end
        end
        drain();
        vectors++;
        if (ops_done !== 16'd4) begin
            miscompares++;
            $display("FAIL basic_ops_done: got %0d want 4", ops_done);
        end
    endtask

    task automatic test_zero_flag();
        out_ready = 1'b1;
        drive(8'hAA, 8'h55, 2'b00, 1'b1);
        vectors += 2;
        if (y !== 8'h00 || zero !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_and: got y=%h zero=%b want y=00 zero=1", y, zero);
        end
        drive(8'hAA, 8'h55, 2'b01, 1'b1);
        if (y !== 8'hFF || zero !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_or: got y=%h zero=%b want y=FF zero=0", y, zero);
        end
        drain();
    endtask

    task automatic test_fill_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive(WIDTH'(8'h11 * (i + 1)), 8'h0F, 2'(i), 1'b1);
        vectors += 2;
        if (count !== CW'(4)) begin miscompares++; $display("FAIL fill_count: got %0d want 4", count); end
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        a        = 8'h55;
        b        = 8'hF0;
        op       = 2'b10;
        in_valid = 1'b1;
        tick(1'b1);
        tick(1'b1);
        out_ready = 1'b1;
        tick(1'b1);
        vectors += 2;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_in_ready: got %b want 1", in_ready); end
        if (count !== CW'(3)) begin miscompares++; $display("FAIL bp_count: got %0d want 3", count); end
        drive(8'h55, 8'hF0, 2'b10, 1'b1);
        vectors++;
        if (count !== CW'(3)) begin miscompares++; $display("FAIL bp_fifth: got count %0d want 3", count); end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(8'h01, 8'h80, 2'b01, 1'b1);
        drive(8'h02, 8'h40, 2'b01, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(WIDTH'($urandom), WIDTH'($urandom), 2'($urandom_range(0, 3)), 1'b1);
            vectors++;
            if (count !== CW'(2)) begin
                miscompares++;
                $display("FAIL b2b_count[%0d]: got %0d want 2", i, count);
            end
        end
        drain();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        drive(8'hDE, 8'hAD, 2'b10, 1'b1);
        drive(8'hBE, 8'hEF, 2'b01, 1'b1);
        drive(8'h12, 8'h34, 2'b11, 1'b1);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        vectors += 5;
        if (count !== '0)       begin miscompares++; $display("FAIL mid_count: got %0d want 0", count); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        if (y !== '0)           begin miscompares++; $display("FAIL mid_y: got %h want 00", y); end
        if (ops_done !== '0)    begin miscompares++; $display("FAIL mid_ops_done: got %0d want 0", ops_done); end
        if (in_ready !== 1'b0)  begin miscompares++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
        #1;
        rst = 1'b0;
        sb.delete();
        exp_ops = '0;
        @(posedge clk);
        #1;
        drive(8'h3C, 8'h0F, 2'b00, 1'b1);
        vectors++;
        if (y !== 8'h0C) begin miscompares++; $display("FAIL mid_new_head: got %h want 0C", y); end
        drain();
    endtask

    task automatic test_counter_wrap();
        in_valid = 1'b0;
        rst      = 1'b1;
        #2;
        rst = 1'b0;
        sb.delete();
        exp_ops = '0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            op       = 2'($urandom_range(0, 3));
            in_valid = 1'b1;
            tick(1'b0);
        end
        drain();
        vectors += 2;
        if (ops_done !== 16'h0001) begin
            miscompares++;
            $display("FAIL wrap_ops_done: got %h want 0001", ops_done);
        end
        if (ops_done !== exp_ops) begin
            miscompares++;
            $display("FAIL wrap_model: got %h want %h", ops_done, exp_ops);
        end
    endtask

    initial begin
        test_reset();
        test_basic_ops();
        test_zero_flag();
        test_fill_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
